// File: rtl/sdc_resp_chk_if.sv
// SD command-response checker handshake: one strobe in with the packet, result flags out.
interface sdc_resp_chk_if;
  logic         resp_strb;
  logic [1:0]   resp_type;
  logic [135:0] resp_packet;
  logic [5:0]   exp_cmd_indx;
  logic         busy;
  logic         done_strb;
  logic [6:0]   crc7_calc;
  logic         crc_good;
  logic         indx_err;
  logic         frame_err;
  logic         resp_ok;
  logic         ovr_err;

  modport master (
    output resp_strb, resp_type, resp_packet, exp_cmd_indx,
    input  busy, done_strb, crc7_calc, crc_good, indx_err, frame_err, resp_ok, ovr_err
  );
  modport slave (
    input  resp_strb, resp_type, resp_packet, exp_cmd_indx,
    output busy, done_strb, crc7_calc, crc_good, indx_err, frame_err, resp_ok, ovr_err
  );
endinterface

// File: rtl/sdc_resp_chk.sv
// SD response checker: multi-cycle CRC7 (BPC bits/clock) plus index and framing checks
// on a latched copy of an R1/R3/R2 response.
module sdc_resp_chk #(
  parameter int BPC   = 1,
  parameter bit R2_EN = 1'b1
) (
  input  logic           gclk,
  input  logic           grst_n,
  sdc_resp_chk_if.slave  rsp_if
);

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bad_bpc
      $error("sdc_resp_chk: BPC must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam int N_R1 = 40 / BPC;
  localparam int N_R2 = 120 / BPC;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t       state_q;
  logic [1:0]   type_q;
  logic         rsv_q;
  logic [5:0]   idx_q;
  logic [7:0]   hdr_q;    // start/tx bits + index field of the latched response
  logic [7:0]   tail_q;   // received CRC + end bit
  logic [119:0] sh_q;     // CRC coverage window, consumed from the MSB end
  logic [6:0]   crc_q;
  logic [6:0]   cnt_q;
  logic         done_q, ovr_q;
  logic [6:0]   crc_out_q;
  logic         good_q, ierr_q, ferr_q, ok_q;

  logic         rsv_in, is_r2_in;
  logic [6:0]   res_crc;
  logic         res_good, res_ierr, res_ferr;

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic [BPC-1:0] d);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb = d[i] ^ r[6];
      r  = {r[5:0], 1'b0} ^ ({7{fb}} & 7'h09);
    end
    return r;
  endfunction

  assign is_r2_in = (rsp_if.resp_type == 2'd2) && R2_EN;
  assign rsv_in   = (rsp_if.resp_type == 2'd3) || ((rsp_if.resp_type == 2'd2) && !R2_EN);

  always_comb begin
    res_crc  = rsv_q ? 7'h00 : crc_q;
    res_good = 1'b0;
    res_ierr = 1'b0;
    res_ferr = 1'b1;
    if (!rsv_q) begin
      res_good = (type_q == 2'd1) ? 1'b1 : (crc_q == tail_q[7:1]);
      res_ierr = (type_q == 2'd0) ? (hdr_q[5:0] != idx_q) : (hdr_q[5:0] != 6'h3F);
      res_ferr = (hdr_q[7:6] != 2'b00) || !tail_q[0];
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q   <= S_IDLE;
      type_q    <= 2'd0;
      rsv_q     <= 1'b0;
      idx_q     <= 6'd0;
      hdr_q     <= 8'd0;
      tail_q    <= 8'd0;
      sh_q      <= '0;
      crc_q     <= 7'd0;
      cnt_q     <= 7'd0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      crc_out_q <= 7'd0;
      good_q    <= 1'b0;
      ierr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rsp_if.resp_strb) begin
            type_q  <= rsp_if.resp_type;
            rsv_q   <= rsv_in;
            idx_q   <= rsp_if.exp_cmd_indx;
            hdr_q   <= is_r2_in ? rsp_if.resp_packet[135:128] : rsp_if.resp_packet[47:40];
            tail_q  <= rsp_if.resp_packet[7:0];
            sh_q    <= is_r2_in ? rsp_if.resp_packet[127:8]
                                : {rsp_if.resp_packet[47:8], 80'd0};
            crc_q   <= 7'h00;
            cnt_q   <= is_r2_in ? 7'(N_R2 - 1) : 7'(N_R1 - 1);
            ovr_q   <= 1'b0;
            state_q <= rsv_in ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (rsp_if.resp_strb) ovr_q <= 1'b1;
          crc_q <= crc_step(crc_q, sh_q[119 -: BPC]);
          sh_q  <= sh_q << BPC;
          if (cnt_q == 7'd0) state_q <= S_DONE;
          else               cnt_q   <= cnt_q - 7'd1;
        end
        S_DONE: begin
          if (rsp_if.resp_strb) ovr_q <= 1'b1;
          done_q    <= 1'b1;
          crc_out_q <= res_crc;
          good_q    <= res_good;
          ierr_q    <= res_ierr;
          ferr_q    <= res_ferr;
          ok_q      <= res_good & ~res_ierr & ~res_ferr;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_if.busy      = (state_q == S_CALC);
  assign rsp_if.done_strb = done_q;
  assign rsp_if.crc7_calc = crc_out_q;
  assign rsp_if.crc_good  = good_q;
  assign rsp_if.indx_err  = ierr_q;
  assign rsp_if.frame_err = ferr_q;
  assign rsp_if.resp_ok   = ok_q;
  assign rsp_if.ovr_err   = ovr_q;

endmodule

// File: tb/tb_sdc_resp_chk.sv
// Scoreboard bench: drives BPC=1 and BPC=8 checkers in lockstep, compares results and latency.
module tb_sdc_resp_chk;
  logic gclk, grst_n;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  sdc_resp_chk_if i1 ();
  sdc_resp_chk_if i8 ();

  sdc_resp_chk #(.BPC(1), .R2_EN(1'b1)) u1 (.gclk(gclk), .grst_n(grst_n), .rsp_if(i1));
  sdc_resp_chk #(.BPC(8), .R2_EN(1'b1)) u8 (.gclk(gclk), .grst_n(grst_n), .rsp_if(i8));

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end
  always @(posedge gclk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] crc;
    logic       good, ierr, ferr, ok;
    int         lat1, lat8, t0;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t e1, e8;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [6:0] m_crc(input logic [135:0] p, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = hi; i >= lo; i--) begin
      fb = p[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic exp_t exp_of(input logic [1:0] t, input logic [135:0] p, input logic [5:0] idx);
    exp_t e;
    logic r2;
    r2 = (t == 2'd2);
    e.t0 = 0;
    if (t == 2'd3) begin
      e.crc = 7'h00; e.good = 1'b0; e.ierr = 1'b0; e.ferr = 1'b1; e.ok = 1'b0;
      e.lat1 = 1; e.lat8 = 1;
      return e;
    end
    e.crc  = r2 ? m_crc(p, 127, 8) : m_crc(p, 47, 8);
    e.good = (t == 2'd1) ? 1'b1 : (e.crc == p[7:1]);
    if (r2)            e.ierr = (p[133:128] != 6'h3F);
    else if (t == 2'd1) e.ierr = (p[45:40] != 6'h3F);
    else               e.ierr = (p[45:40] != idx);
    e.ferr = ((r2 ? p[135:134] : p[47:46]) != 2'b00) || !p[0];
    e.ok   = e.good && !e.ierr && !e.ferr;
    e.lat1 = r2 ? 121 : 41;
    e.lat8 = r2 ? 16 : 6;
    return e;
  endfunction

  task automatic cmp_res(input string p, input exp_t e, input int lat, input logic [6:0] crc,
                         input logic good, ierr, ferr, ok, busy);
    chk({p, "_crc7"}, 32'(crc), 32'(e.crc));
    chk({p, "_crc_good"}, 32'(good), 32'(e.good));
    chk({p, "_indx_err"}, 32'(ierr), 32'(e.ierr));
    chk({p, "_frame_err"}, 32'(ferr), 32'(e.ferr));
    chk({p, "_resp_ok"}, 32'(ok), 32'(e.ok));
    chk({p, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({p, "_latency"}, 32'(cyc - e.t0), 32'(lat));
  endtask

  always @(negedge gclk) begin
    if (i1.done_strb) begin
      if (q1.size() == 0) chk("b1_spurious_done", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        cmp_res("b1", e1, e1.lat1, i1.crc7_calc, i1.crc_good, i1.indx_err, i1.frame_err,
                i1.resp_ok, i1.busy);
      end
    end
    if (i8.done_strb) begin
      if (q8.size() == 0) chk("b8_spurious_done", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        cmp_res("b8", e8, e8.lat8, i8.crc7_calc, i8.crc_good, i8.indx_err, i8.frame_err,
                i8.resp_ok, i8.busy);
      end
    end
  end

  // Pulse resp_strb on both DUTs; scramble inputs afterwards since only the latched copy counts.
  task automatic strobe(input logic [1:0] t, input logic [135:0] p, input logic [5:0] idx,
                        input bit push, input exp_t e);
    @(negedge gclk);
    i1.resp_type = t; i1.resp_packet = p; i1.exp_cmd_indx = idx; i1.resp_strb = 1'b1;
    i8.resp_type = t; i8.resp_packet = p; i8.exp_cmd_indx = idx; i8.resp_strb = 1'b1;
    if (push) begin
      e.t0 = cyc + 1;
      q1.push_back(e);
      q8.push_back(e);
    end
    @(negedge gclk);
    i1.resp_strb = 1'b0; i8.resp_strb = 1'b0;
    i1.resp_packet = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    i8.resp_packet = i1.resp_packet;
    i1.exp_cmd_indx = 6'($urandom); i8.exp_cmd_indx = i1.exp_cmd_indx;
  endtask

  task automatic send(input logic [1:0] t, input logic [135:0] p, input logic [5:0] idx);
    strobe(t, p, idx, 1'b1, exp_of(t, p, idx));
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q1.size() != 0 || q8.size() != 0) && n < 400) begin
      @(negedge gclk);
      n++;
    end
    chk("wait_done_pending", 32'(q1.size() + q8.size()), 32'd0);
    repeat (2) @(negedge gclk);
  endtask

  task automatic chk_zero(input string p, input logic busy, done, input logic [6:0] crc,
                          input logic good, ierr, ferr, ok, ovr);
    chk({p, "_rst_busy"}, 32'(busy), 32'd0);
    chk({p, "_rst_done"}, 32'(done), 32'd0);
    chk({p, "_rst_crc7"}, 32'(crc), 32'd0);
    chk({p, "_rst_flags"}, 32'({good, ierr, ferr, ok, ovr}), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [135:0] p;
    grst_n = 1'b0;
    i1.resp_strb = 1'b0; i1.resp_type = 2'd0; i1.resp_packet = '0; i1.exp_cmd_indx = 6'd0;
    i8.resp_strb = 1'b0; i8.resp_type = 2'd0; i8.resp_packet = '0; i8.exp_cmd_indx = 6'd0;
    #1;
    chk_zero("b1", i1.busy, i1.done_strb, i1.crc7_calc, i1.crc_good, i1.indx_err,
             i1.frame_err, i1.resp_ok, i1.ovr_err);
    chk_zero("b8", i8.busy, i8.done_strb, i8.crc7_calc, i8.crc_good, i8.indx_err,
             i8.frame_err, i8.resp_ok, i8.ovr_err);
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;

    // Known-answer vectors
    e = '{crc: 7'h09, good: 1'b1, ierr: 1'b0, ferr: 1'b0, ok: 1'b1, lat1: 41, lat8: 6, t0: 0};
    strobe(2'd0, 136'h08000001AA13, 6'd8, 1'b1, e);
    @(negedge gclk);
    chk("b1_busy_in_calc", 32'(i1.busy), 32'd1);
    wait_done();
    e = '{crc: 7'h09, good: 1'b0, ierr: 1'b0, ferr: 1'b0, ok: 1'b0, lat1: 41, lat8: 6, t0: 0};
    strobe(2'd0, 136'h08000001AA15, 6'd8, 1'b1, e);
    wait_done();
    e = '{crc: 7'h4A, good: 1'b1, ierr: 1'b0, ferr: 1'b1, ok: 1'b0, lat1: 41, lat8: 6, t0: 0};
    strobe(2'd0, 136'h400000000095, 6'd0, 1'b1, e);
    wait_done();
    e = '{crc: 7'h09, good: 1'b1, ierr: 1'b1, ferr: 1'b0, ok: 1'b0, lat1: 41, lat8: 6, t0: 0};
    strobe(2'd0, 136'h08000001AA13, 6'd9, 1'b1, e);
    wait_done();

    // Random well-formed R1, then R3 and reserved type
    for (int k = 0; k < 3; k++) begin
      p = '0;
      p[45:40] = 6'($urandom);
      p[39:8]  = $urandom;
      p[7:1]   = m_crc(p, 47, 8);
      p[0]     = 1'b1;
      send(2'd0, p, p[45:40]);
      wait_done();
    end
    send(2'd1, 136'h3F80FF8000FF, 6'd1);
    wait_done();
    send(2'd3, 136'h08000001AA13, 6'd8);
    wait_done();

    // R2 with valid CRC, then a single flipped bit
    p = '0;
    p[133:128] = 6'h3F;
    p[127:8]   = {$urandom, $urandom, $urandom, 24'($urandom)};
    p[7:1]     = m_crc(p, 127, 8);
    p[0]       = 1'b1;
    send(2'd2, p, 6'd2);
    wait_done();
    p[64] = ~p[64];
    send(2'd2, p, 6'd2);
    wait_done();

    // Overrun: second strobe 5 cycles in is ignored
    send(2'd0, 136'h08000001AA13, 6'd8);
    repeat (3) @(negedge gclk);
    strobe(2'd0, 136'h400000000095, 6'd0, 1'b0, e);
    wait_done();
    chk("b1_ovr_set", 32'(i1.ovr_err), 32'd1);
    chk("b8_ovr_set", 32'(i8.ovr_err), 32'd1);
    send(2'd0, 136'h08000001AA13, 6'd8);
    chk("b1_ovr_clr", 32'(i1.ovr_err), 32'd0);
    wait_done();
    chk("b8_ovr_clr", 32'(i8.ovr_err), 32'd0);

    // Reset mid-CALC on the BPC=1 instance aborts without a done pulse
    send(2'd0, 136'h08000001AA13, 6'd8);
    repeat (19) @(negedge gclk);
    chk("b1_busy_before_rst", 32'(i1.busy), 32'd1);
    grst_n = 1'b0;
    #1;
    q1.delete();
    q8.delete();
    chk_zero("b1m", i1.busy, i1.done_strb, i1.crc7_calc, i1.crc_good, i1.indx_err,
             i1.frame_err, i1.resp_ok, i1.ovr_err);
    repeat (2) @(negedge gclk);
    grst_n = 1'b1;
    repeat (60) @(negedge gclk);
    send(2'd0, 136'h08000001AA13, 6'd8);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
